// File: rtl/piradip_axis_sample_capture.sv
// Stream-domain write engine for the sample buffer: takes an unthrottled AXI-Stream sample feed
// and writes accepted beats into a RAM window, either looping or stopping after one pass.
module piradip_axis_sample_capture #(
   parameter int DATA_WIDTH   = 128,
   parameter int OFFSET_WIDTH = 5,
   parameter int COUNT_WIDTH  = 32
) (
   input  logic                    aclk,
   input  logic                    aresetn,
   input  logic [DATA_WIDTH-1:0]   s_tdata,
   input  logic                    s_tvalid,
   output logic                    s_tready,
   input  logic                    ctrl_update,
   input  logic                    ctrl_active,
   input  logic                    ctrl_one_shot,
   input  logic [OFFSET_WIDTH-1:0] ctrl_start,
   input  logic [OFFSET_WIDTH-1:0] ctrl_end,
   input  logic                    i_en,
   input  logic                    q_en,
   output logic                    mem_we,
   output logic [OFFSET_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   output logic                    stopped,
   output logic                    wrap_toggle,
   output logic [COUNT_WIDTH-1:0]  capture_count
);

   localparam int HALF = DATA_WIDTH / 2;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t                  state;
   logic [OFFSET_WIDTH-1:0] ptr;
   logic [OFFSET_WIDTH-1:0] win_start;
   logic [OFFSET_WIDTH-1:0] win_end;
   logic                    win_one_shot;

   logic                    start_req;
   logic                    beat;
   logic [DATA_WIDTH-1:0]   masked_data;

   // The ADC feed is never back-pressured; only reset withholds ready.
   assign s_tready  = aresetn;
   assign start_req = ctrl_update & ctrl_active;
   assign beat      = s_tvalid & s_tready;

   assign masked_data = {s_tdata[DATA_WIDTH-1:HALF] & {HALF{i_en}},
                         s_tdata[HALF-1:0]          & {HALF{q_en}}};

   // NOTE: all state below uses non-blocking assignments so every branch sees pre-edge values.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state         <= ST_IDLE;
         ptr           <= '0;
         win_start     <= '0;
         win_end       <= '1;
         win_one_shot  <= 1'b0;
         mem_we        <= 1'b0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         stopped       <= 1'b1;
         wrap_toggle   <= 1'b0;
         capture_count <= '0;
      end else begin
         mem_we <= 1'b0;
         if (start_req) begin
            // Start or restart: the beat arriving in this cycle is dropped.
            state         <= ST_RUN;
            ptr           <= ctrl_start;
            win_start     <= ctrl_start;
            win_end       <= ctrl_end;
            win_one_shot  <= ctrl_one_shot;
            capture_count <= '0;
            stopped       <= 1'b0;
         end else if (state == ST_RUN && beat) begin
            mem_we    <= 1'b1;
            mem_addr  <= ptr;
            mem_wdata <= masked_data;
            if (capture_count != '1) begin
               capture_count <= capture_count + 1'b1;
            end
            if (ptr != win_end) begin
               ptr <= ptr + 1'b1;
            end else if (win_one_shot) begin
               state   <= ST_IDLE;
               stopped <= 1'b1;
            end else begin
               ptr         <= win_start;
               wrap_toggle <= ~wrap_toggle;
            end
         end
      end
   end

endmodule

// File: tb/tb_piradip_axis_sample_capture.sv
// Bench for piradip_axis_sample_capture: a beat-index window model checked every cycle, plus
// directed scenarios with literal expectations on the written addresses and data.
module tb_piradip_axis_sample_capture;

   localparam int DW    = 128;
   localparam int OW    = 5;
   localparam int CW    = 32;
   localparam int DEPTH = 1 << OW;

   logic            aclk          = 1'b0;
   logic            aresetn       = 1'b1;
   logic [DW-1:0]   s_tdata       = '0;
   logic            s_tvalid      = 1'b0;
   logic            s_tready;
   logic            ctrl_update   = 1'b0;
   logic            ctrl_active   = 1'b0;
   logic            ctrl_one_shot = 1'b0;
   logic [OW-1:0]   ctrl_start    = '0;
   logic [OW-1:0]   ctrl_end      = '0;
   logic            i_en          = 1'b1;
   logic            q_en          = 1'b1;
   logic            mem_we;
   logic [OW-1:0]   mem_addr;
   logic [DW-1:0]   mem_wdata;
   logic            stopped;
   logic            wrap_toggle;
   logic [CW-1:0]   capture_count;

   piradip_axis_sample_capture #(
      .DATA_WIDTH   (DW),
      .OFFSET_WIDTH (OW),
      .COUNT_WIDTH  (CW)
   ) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .s_tdata       (s_tdata),
      .s_tvalid      (s_tvalid),
      .s_tready      (s_tready),
      .ctrl_update   (ctrl_update),
      .ctrl_active   (ctrl_active),
      .ctrl_one_shot (ctrl_one_shot),
      .ctrl_start    (ctrl_start),
      .ctrl_end      (ctrl_end),
      .i_en          (i_en),
      .q_en          (q_en),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .stopped       (stopped),
      .wrap_toggle   (wrap_toggle),
      .capture_count (capture_count)
   );

   always #5 aclk = ~aclk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   // Model: the k-th accepted beat after a start lands at start + (k mod window length).
   bit            m_run   = 1'b0;
   int            m_k     = 0;
   logic [OW-1:0] m_start = '0;
   logic [OW-1:0] m_end   = '1;
   bit            m_os    = 1'b0;
   logic          exp_we      = 1'b0;
   logic [OW-1:0] exp_addr    = '0;
   logic [DW-1:0] exp_wdata   = '0;
   logic          exp_stopped = 1'b1;
   logic          exp_wrap    = 1'b0;
   logic [CW-1:0] exp_count   = '0;

   task automatic model_step();
      int len;
      int pos;
      if (!aresetn) begin
         m_run = 1'b0; m_k = 0; m_start = '0; m_end = '1; m_os = 1'b0;
         exp_we = 1'b0; exp_addr = '0; exp_wdata = '0;
         exp_stopped = 1'b1; exp_wrap = 1'b0; exp_count = '0;
      end else begin
         exp_we = 1'b0;
         if (ctrl_update && ctrl_active) begin
            m_run = 1'b1; m_k = 0;
            m_start = ctrl_start; m_end = ctrl_end; m_os = ctrl_one_shot;
            exp_count = '0; exp_stopped = 1'b0;
         end else if (m_run && s_tvalid) begin
            len = (int'(m_end) - int'(m_start) + DEPTH) % DEPTH + 1;
            pos = m_k % len;
            exp_we    = 1'b1;
            exp_addr  = OW'((int'(m_start) + pos) % DEPTH);
            exp_wdata = {i_en ? s_tdata[DW-1:DW/2] : {(DW/2){1'b0}},
                         q_en ? s_tdata[DW/2-1:0]  : {(DW/2){1'b0}}};
            m_k++;
            if (exp_count != '1) exp_count = exp_count + 1;
            if (pos == len - 1) begin
               if (m_os) begin
                  m_run = 1'b0;
                  exp_stopped = 1'b1;
               end else begin
                  exp_wrap = ~exp_wrap;
               end
            end
         end
      end
   endtask

   always @(posedge aclk or negedge aresetn) model_step();

   // Compare process: every output against the model on each falling edge.
   task automatic compare_step();
      check("s_tready", s_tready, aresetn);
      check("mem_we", mem_we, exp_we);
      if (exp_we) begin
         check("mem_addr", mem_addr, exp_addr);
         check("mem_wdata", mem_wdata, exp_wdata);
      end
      check("stopped", stopped, exp_stopped);
      check("wrap_toggle", wrap_toggle, exp_wrap);
      check("capture_count", capture_count, exp_count);
   endtask

   always @(negedge aclk) compare_step();

   // Write log and RAM image built from what the DUT actually writes.
   int            log_q[$];
   logic [DW-1:0] ram [DEPTH];
   int            toggles   = 0;
   logic          last_wrap = 1'b0;

   task automatic monitor_step();
      if (mem_we === 1'b1) begin
         log_q.push_back(int'(mem_addr));
         ram[mem_addr] = mem_wdata;
      end
      if (wrap_toggle !== last_wrap) toggles++;
      last_wrap = wrap_toggle;
   endtask

   always @(negedge aclk) monitor_step();

   function automatic logic [DW-1:0] pat(input int i);
      return {32'h1111_0000 + i, 32'h2222_0000 + i, 32'h3333_0000 + i, 32'h4444_0000 + i};
   endfunction

   task automatic settle();
      @(negedge aclk);
      #1;
   endtask

   task automatic start_cap(input logic os, input logic [OW-1:0] st, input logic [OW-1:0] en);
      ctrl_update = 1'b1; ctrl_active = 1'b1;
      ctrl_one_shot = os; ctrl_start = st; ctrl_end = en;
      @(negedge aclk);
      #1;
      ctrl_update = 1'b0; ctrl_active = 1'b0;
   endtask

   task automatic send(input logic [DW-1:0] d);
      s_tvalid = 1'b1; s_tdata = d;
      @(negedge aclk);
      #1;
      s_tvalid = 1'b0;
   endtask

   task automatic check_log(input string name, input int exp_a[$]);
      check({name, "_len"}, log_q.size(), exp_a.size());
      for (int i = 0; i < exp_a.size() && i < log_q.size(); i++) begin
         check($sformatf("%s_addr%0d", name, i), log_q[i], exp_a[i]);
      end
   endtask

   localparam logic [DW-1:0] AB = {64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB};

   initial begin
      int t0;
      #1 aresetn = 1'b0;
      repeat (2) @(negedge aclk);
      #2 aresetn = 1'b1;
      check("rst_stopped", stopped, 1'b1);
      check("rst_wrap", wrap_toggle, 1'b0);
      check("rst_count", capture_count, '0);
      check("rst_we", mem_we, 1'b0);
      settle();

      // One-shot window 0..3 with six beats offered.
      log_q.delete();
      start_cap(1'b1, 5'd0, 5'd3);
      for (int i = 0; i < 6; i++) send(pat(i));
      settle();
      check_log("oneshot", '{0, 1, 2, 3});
      for (int i = 0; i < 4; i++) check($sformatf("oneshot_data%0d", i), ram[i], pat(i));
      check("oneshot_stopped", stopped, 1'b1);
      check("oneshot_count", capture_count, 32'd4);

      // Looping window 2..4, seven beats.
      log_q.delete();
      t0 = toggles;
      start_cap(1'b0, 5'd2, 5'd4);
      for (int i = 0; i < 7; i++) send(pat(10 + i));
      settle();
      check_log("loop", '{2, 3, 4, 2, 3, 4, 2});
      check("loop_toggles", toggles - t0, 2);
      check("loop_stopped", stopped, 1'b0);
      check("loop_count", capture_count, 32'd7);

      // One-shot window crossing address zero.
      log_q.delete();
      start_cap(1'b1, 5'd30, 5'd1);
      for (int i = 0; i < 6; i++) send(pat(20 + i));
      settle();
      check_log("cross", '{30, 31, 0, 1});
      check("cross_stopped", stopped, 1'b1);

      // I/Q masking in a one-word looping window.
      t0 = toggles;
      start_cap(1'b0, 5'd5, 5'd5);
      i_en = 1'b0; q_en = 1'b1;
      send(AB);
      settle();
      check("mask_q_only", ram[5], {64'h0, 64'hBBBB_BBBB_BBBB_BBBB});
      i_en = 1'b1; q_en = 1'b0;
      send(AB);
      settle();
      check("mask_i_only", ram[5], {64'hAAAA_AAAA_AAAA_AAAA, 64'h0});
      check("one_word_toggles", toggles - t0, 2);
      i_en = 1'b1; q_en = 1'b1;

      // Restart during an 8-word loop, then an inactive update that must not disturb it.
      log_q.delete();
      start_cap(1'b0, 5'd8, 5'd15);
      for (int i = 0; i < 3; i++) send(pat(30 + i));
      s_tvalid = 1'b1; s_tdata = pat(99);
      start_cap(1'b0, 5'd8, 5'd15);
      s_tvalid = 1'b0;
      for (int i = 0; i < 2; i++) send(pat(40 + i));
      ctrl_update = 1'b1; ctrl_active = 1'b0;
      ctrl_one_shot = 1'b1; ctrl_start = 5'd0; ctrl_end = 5'd0;
      send(pat(42));
      ctrl_update = 1'b0;
      send(pat(43));
      settle();
      check_log("restart", '{8, 9, 10, 8, 9, 10, 11});
      check("restart_count", capture_count, 32'd4);
      check("restart_stopped", stopped, 1'b0);
      check("restart_first", ram[8], pat(40));

      // Reset in the middle of a running capture with valid held high.
      log_q.delete();
      start_cap(1'b0, 5'd0, 5'd7);
      s_tvalid = 1'b1; s_tdata = pat(50);
      repeat (3) @(negedge aclk);
      #2 aresetn = 1'b0;
      #1;
      check("inrst_tready", s_tready, 1'b0);
      check("inrst_we", mem_we, 1'b0);
      check("inrst_stopped", stopped, 1'b1);
      repeat (2) @(negedge aclk);
      #2 aresetn = 1'b1;
      repeat (4) @(negedge aclk);
      #1 s_tvalid = 1'b0;
      settle();
      check("postrst_writes", log_q.size(), 3);
      check("postrst_stopped", stopped, 1'b1);
      check("postrst_count", capture_count, '0);
      check("postrst_wrap", wrap_toggle, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
